// File: rtl/step_counter.sv
// Up/down counter register with run-time step, clear/load priority, wrap or
// saturate behaviour, a registered overflow pulse and a zero decode.
module step_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH:0]   sum_p0;
  logic [WIDTH:0]   diff_p0;
  logic [WIDTH-1:0] next_p0;
  logic             ovf_next_p0;

  // Resolve an out-of-range result: clamp when saturating, else keep the low bits.
  function automatic logic [WIDTH-1:0] bound(input logic [WIDTH:0] raw, input logic up);
    if (SATURATE && raw[WIDTH])
      bound = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    else
      bound = raw[WIDTH-1:0];
  endfunction

  assign sum_p0  = {1'b0, out} + {1'b0, step};
  assign diff_p0 = {1'b0, out} - {1'b0, step};

  always_comb begin
    next_p0     = out;
    ovf_next_p0 = 1'b0;
    if (clr) begin
      next_p0 = '0;
    end else if (load) begin
      next_p0 = in;
    end else if (inc && !dec) begin
      next_p0     = bound(sum_p0, 1'b1);
      ovf_next_p0 = sum_p0[WIDTH];
    end else if (dec && !inc) begin
      // Bit WIDTH of the extended difference is the borrow (step > out).
      next_p0     = bound(diff_p0, 1'b0);
      ovf_next_p0 = diff_p0[WIDTH];
    end
  end

  // Stage boundary: command result registered onto out/ovf.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out <= '0;
      ovf <= 1'b0;
    end else begin
      out <= next_p0;
      ovf <= ovf_next_p0;
    end
  end

  assign zero = (out == '0);

endmodule

// File: tb/tb_step_counter.sv
// Directed scoreboard bench for step_counter: 16-bit wrap, 16-bit saturate
// and 8-bit wrap instances, each compared against a reference model.
module tb_step_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        clr_a = 0, load_a = 0, inc_a = 0, dec_a = 0;
  logic [15:0] in_a = '0, step_a = '0, out_a;
  logic        ovf_a, zero_a;

  logic        clr_b = 0, load_b = 0, inc_b = 0, dec_b = 0;
  logic [15:0] in_b = '0, step_b = '0, out_b;
  logic        ovf_b, zero_b;

  logic        clr_c = 0, load_c = 0, inc_c = 0, dec_c = 0;
  logic [7:0]  in_c = '0, step_c = '0, out_c;
  logic        ovf_c, zero_c;

  step_counter #(.WIDTH(16), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .clr(clr_a), .load(load_a), .in(in_a),
    .inc(inc_a), .dec(dec_a), .step(step_a), .out(out_a), .ovf(ovf_a), .zero(zero_a));

  step_counter #(.WIDTH(16), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .clr(clr_b), .load(load_b), .in(in_b),
    .inc(inc_b), .dec(dec_b), .step(step_b), .out(out_b), .ovf(ovf_b), .zero(zero_b));

  step_counter #(.WIDTH(8), .SATURATE(1'b0)) dut_w8 (
    .clock(clock), .reset(reset), .clr(clr_c), .load(load_c), .in(in_c),
    .inc(inc_c), .dec(dec_c), .step(step_c), .out(out_c), .ovf(ovf_c), .zero(zero_c));

  always #5 clock = ~clock;

  typedef struct {
    int     sel;
    string  tag;
    longint out;
    bit     ovf;
  } exp_t;

  exp_t   q[$];
  longint mdl[3];
  int     checks = 0;
  int     passes = 0;

  function automatic longint get_out(input int sel);
    case (sel)
      0:       return longint'(out_a);
      1:       return longint'(out_b);
      default: return longint'(out_c);
    endcase
  endfunction

  function automatic bit get_ovf(input int sel);
    case (sel)
      0:       return ovf_a;
      1:       return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  function automatic bit get_zero(input int sel);
    case (sel)
      0:       return zero_a;
      1:       return zero_b;
      default: return zero_c;
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic drive(input int sel, input bit c, input bit l, input logic [15:0] iv,
                       input bit i, input bit d, input logic [15:0] st);
    case (sel)
      0: begin clr_a = c; load_a = l; in_a = iv; inc_a = i; dec_a = d; step_a = st; end
      1: begin clr_b = c; load_b = l; in_b = iv; inc_b = i; dec_b = d; step_b = st; end
      default: begin
        clr_c = c; load_c = l; in_c = iv[7:0]; inc_c = i; dec_c = d; step_c = st[7:0];
      end
    endcase
  endtask

  // Independent reference: plain integer arithmetic on the model value.
  task automatic cmd(input int sel, input string tag, input bit c, input bit l,
                     input longint iv, input bit i, input bit d, input longint st);
    longint maxv, v, s;
    bit     sat, o;
    exp_t   e, got;
    maxv = (sel == 2) ? 64'd255 : 64'd65535;
    sat  = (sel == 1);
    v    = mdl[sel];
    o    = 1'b0;
    if (c) v = 0;
    else if (l) v = iv;
    else if (i && !d) begin
      s = v + st;
      if (s > maxv) begin o = 1'b1; v = sat ? maxv : s - (maxv + 1); end
      else v = s;
    end else if (d && !i) begin
      if (st > v) begin o = 1'b1; v = sat ? 0 : v - st + maxv + 1; end
      else v = v - st;
    end
    mdl[sel] = v;
    @(negedge clock);
    drive(sel, c, l, iv[15:0], i, d, st[15:0]);
    e.sel = sel; e.tag = tag; e.out = v; e.ovf = o;
    q.push_back(e);
    @(posedge clock);
    #1;
    drive(sel, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    got = q.pop_front();
    chk({got.tag, ".out"}, get_out(got.sel), got.out);
    chk({got.tag, ".ovf"}, longint'(get_ovf(got.sel)), longint'(got.ovf));
    chk({got.tag, ".zero"}, longint'(get_zero(got.sel)), longint'(got.out == 0));
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s%0d.out", tag, k), get_out(k), 0);
      chk($sformatf("%s%0d.ovf", tag, k), longint'(get_ovf(k)), 0);
      chk($sformatf("%s%0d.zero", tag, k), longint'(get_zero(k)), 1);
    end
  endtask

  initial begin
    mdl[0] = 0; mdl[1] = 0; mdl[2] = 0;
    #12;
    chk_reset_state("rst");
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-count on the wrap instance.
    cmd(0, "ld1234", 0, 1, 'h1234, 0, 0, 0);
    cmd(0, "inc_a1", 0, 0, 0, 1, 0, 1);
    cmd(0, "inc_a2", 0, 0, 0, 1, 0, 1);
    cmd(0, "inc_a3", 0, 0, 0, 1, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("midrst");
    mdl[0] = 0; mdl[1] = 0; mdl[2] = 0;
    @(negedge clock);
    reset = 1'b0;
    cmd(0, "post_rst_inc", 0, 0, 0, 1, 0, 1);

    // Wrap boundaries.
    cmd(0, "ldFFFF", 0, 1, 'hFFFF, 0, 0, 0);
    cmd(0, "wrap1", 0, 0, 0, 1, 0, 1);
    cmd(0, "ldFFFB", 0, 1, 'hFFFB, 0, 0, 0);
    cmd(0, "wrap5", 0, 0, 0, 1, 0, 5);
    cmd(0, "idle", 0, 0, 0, 0, 0, 0);
    cmd(0, "ldFFF0", 0, 1, 'hFFF0, 0, 0, 0);
    cmd(0, "exact_top", 0, 0, 0, 1, 0, 'hF);

    // Down-count and underflow.
    cmd(0, "ld5", 0, 1, 5, 0, 0, 0);
    cmd(0, "dec_to0", 0, 0, 0, 0, 1, 5);
    cmd(0, "underflow", 0, 0, 0, 0, 1, 1);

    // Priority and simultaneous commands.
    cmd(0, "clr_prio", 1, 1, 'hAAAA, 1, 0, 1);
    cmd(0, "load_prio", 0, 1, 'h00FF, 1, 0, 1);
    cmd(0, "ld10", 0, 1, 'h0010, 0, 0, 0);
    cmd(0, "inc_dec", 0, 0, 0, 1, 1, 3);
    cmd(0, "step0", 0, 0, 0, 1, 0, 0);
    cmd(0, "dec_step0", 0, 0, 0, 0, 1, 0);

    // Saturate instance.
    cmd(1, "s_ldFFFB", 0, 1, 'hFFFB, 0, 0, 0);
    cmd(1, "s_inc4a", 0, 0, 0, 1, 0, 4);
    cmd(1, "s_inc4b", 0, 0, 0, 1, 0, 4);
    cmd(1, "s_inc4c", 0, 0, 0, 1, 0, 4);
    cmd(1, "s_idle", 0, 0, 0, 0, 0, 0);
    cmd(1, "s_ld3", 0, 1, 3, 0, 0, 0);
    cmd(1, "s_dec5", 0, 0, 0, 0, 1, 5);
    cmd(1, "s_dec_at0", 0, 0, 0, 0, 1, 1);
    cmd(1, "s_ld10", 0, 1, 'h10, 0, 0, 0);
    cmd(1, "s_dec3", 0, 0, 0, 0, 1, 3);

    // 8-bit instance.
    cmd(2, "w8_ldFE", 0, 1, 'hFE, 0, 0, 0);
    cmd(2, "w8_inc3", 0, 0, 0, 1, 0, 3);
    cmd(2, "w8_dec2", 0, 0, 0, 0, 1, 2);
    cmd(2, "w8_inc0", 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
